// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type and baud divider helpers for the UART blocks.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_e;
  function automatic int calc_div(input int clk_freq, input int baud, input int os);
    return clk_freq / (baud * os);
  endfunction
  function automatic int cnt_w(input int div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction
  localparam int DEF_DIV = calc_div(100_000_000, 9600, 16);
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: one-cycle tick every DIV clocks; clr holds the phase at zero.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int DIV = DEF_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int CNT_W = cnt_w(DIV);
  if (DIV < 2) begin : g_div_chk
    $error("uart_baud_tick: DIV must be at least 2");
  end
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    tick = !clr && (cnt_q == CNT_W'(DIV - 1));
    cnt_d = (clr || tick) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: oversampling UART receiver with mid-bit sampling.
// Define UART_RX_PARITY_EN to add a parity bit (PARITY_ODD selects odd parity).
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);
  localparam int DIV  = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int SC_W = $clog2(OVERSAMPLE + 1);
  localparam int BI_W = $clog2(DATA_BITS);
  if (OVERSAMPLE % 2 != 0 || OVERSAMPLE < 8) begin : g_os_chk
    $error("uart_rx_sampler: OVERSAMPLE must be even and >= 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_db_chk
    $error("uart_rx_sampler: DATA_BITS must be 5..9");
  end
  state_e state_q, state_d;
  logic rx_s1_q, rx_s2_q, rx_s;
  logic [SC_W-1:0] sc_q, sc_d, sc_inc;
  logic [BI_W-1:0] bi_q, bi_d;
  logic [DATA_BITS-1:0] sh_q, sh_d, data_q, data_d;
  logic dv_q, dv_d, fe_q, fe_d, busy_q, busy_d;
  logic tick, mid, stop_ok;
`ifdef UART_RX_PARITY_EN
  logic pe_q, pe_d;
`endif
  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state_q == IDLE),
    .tick (tick)
  );
  assign rx_s = rx_s2_q;
  always_comb begin
    sc_inc = sc_q + 1'b1;
    // START samples half a bit in so every later sample lands mid-bit
    mid = tick && (sc_inc == ((state_q == START) ? SC_W'(OVERSAMPLE / 2) : SC_W'(OVERSAMPLE)));
`ifdef UART_RX_PARITY_EN
    stop_ok = rx_s && !pe_q;
    pe_d = pe_q;
`else
    stop_ok = rx_s;
`endif
    state_d = state_q;
    sc_d = mid ? '0 : (tick ? sc_inc : sc_q);
    bi_d = bi_q;
    sh_d = sh_q;
    data_d = data_q;
    dv_d = 1'b0;
    fe_d = 1'b0;
    case (state_q)
      IDLE: begin
        sc_d = '0;
`ifdef UART_RX_PARITY_EN
        pe_d = 1'b0;
`endif
        if (!rx_s) state_d = START;
      end
      START: if (mid) begin
        state_d = rx_s ? IDLE : DATA;
        bi_d = '0;
      end
      DATA: if (mid) begin
        sh_d = {rx_s, sh_q[DATA_BITS-1:1]};
        bi_d = bi_q + 1'b1;
`ifdef UART_RX_PARITY_EN
        if (bi_q == BI_W'(DATA_BITS - 1)) state_d = PARITY;
`else
        if (bi_q == BI_W'(DATA_BITS - 1)) state_d = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (mid) begin
        pe_d = rx_s != (^sh_q ^ PARITY_ODD);
        state_d = STOP;
      end
`endif
      STOP: if (mid) begin
        data_d = stop_ok ? sh_q : data_q;
        dv_d = stop_ok;
        fe_d = !stop_ok;
        state_d = rx_s ? IDLE : BREAK;
      end
      BREAK: if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      state_q <= IDLE;
      sc_q <= '0;
      bi_q <= '0;
      sh_q <= '0;
      data_q <= '0;
      dv_q <= 1'b0;
      fe_q <= 1'b0;
      busy_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_q <= 1'b0;
`endif
    end else begin
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
      state_q <= state_d;
      sc_q <= sc_d;
      bi_q <= bi_d;
      sh_q <= sh_d;
      data_q <= data_d;
      dv_q <= dv_d;
      fe_q <= fe_d;
      busy_q <= busy_d;
`ifdef UART_RX_PARITY_EN
      pe_q <= pe_d;
`endif
    end
  assign data_out = data_q;
  assign data_valid = dv_q;
  assign frame_err = fe_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb_uart_rx_sampler: table-driven frames plus hand-written corner cases, checked by a pulse scoreboard.
module tb_uart_rx_sampler;
  localparam int BIT = 160;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic [7:0] data_out;
  logic data_valid, frame_err, busy;
  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap;
  } vec_t;
  typedef struct {
    logic       err;
    logic [7:0] data;
  } exp_t;
  exp_t sb[$];
  int dv_cyc[$];
  int falls[$];
  vec_t vec[6];
  int checks = 0, failures = 0;
  int cyc = 0, n_dv = 0, n_fe = 0, n_dv_exp = 0, n_fe_exp = 0;
  logic [7:0] model_last = 8'h00;

  uart_rx_sampler #(
    .CLK_FREQ  (1_600_000),
    .BAUD      (10_000),
    .OVERSAMPLE(16),
    .DATA_BITS (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .data_out  (data_out),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int got, input int lo, input int hi);
    checks++;
    if (got < lo || got > hi) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d..%0d", name, got, lo, hi);
    end
  endtask

  // scoreboard: every pulse must match the oldest pending expectation
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (data_valid || frame_err)) begin
        chk("dv_fe_exclusive", int'(data_valid & frame_err), 0);
        if (data_valid) begin
          n_dv++;
          dv_cyc.push_back(cyc);
        end
        if (frame_err) n_fe++;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse dv=%0b fe=%0b data_out=%0h", data_valid, frame_err, data_out);
        end else begin
          e = sb.pop_front();
          chk("pulse_is_err", int'(frame_err), int'(e.err));
          chk("pulse_data", int'(data_out), int'(e.data));
        end
      end
    end
  end

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_ok, input int tail,
                            output int fall);
    exp_t e;
    logic ok;
    ok = stop && par_ok;
    e.err = !ok;
    e.data = ok ? d : model_last;
    if (ok) begin
      model_last = d;
      n_dv_exp++;
    end else n_fe_exp++;
    sb.push_back(e);
    fall = cyc;
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ !par_ok;
    repeat (BIT) @(negedge clk);
`endif
    rx = stop;
    repeat (BIT) @(negedge clk);
    repeat (tail) @(negedge clk);
    rx = 1'b1;
  endtask

  initial begin
    int f, bc, fe0;
    logic [7:0] d5;
    vec[0] = '{8'hA5, 1'b1, 300};
    vec[1] = '{8'h00, 1'b1, 0};
    vec[2] = '{8'hFF, 1'b1, 300};
    vec[3] = '{8'h5A, 1'b1, 50};
    vec[4] = '{8'h0F, 1'b1, 0};
    vec[5] = '{8'hF0, 1'b1, 200};
    repeat (5) @(negedge clk);
    chk("rst_data_out", int'(data_out), 0);
    chk("rst_data_valid", int'(data_valid), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_busy", int'(busy), 0);
    for (int i = 0; i < 6; i++) begin
      send_frame(vec[i].data, vec[i].stop, 1'b1, vec[i].gap, f);
      falls.push_back(f);
      chk("hold_after_frame", int'(data_out), int'(model_last));
    end
    if (dv_cyc.size() >= 3) begin
      chk_rng("valid_latency", dv_cyc[0] - falls[0] - 1, 1517, 1523);
      chk_rng("back_to_back_spacing", dv_cyc[2] - dv_cyc[1], 1597, 1603);
    end else begin
      checks++;
      failures++;
      $display("FAIL valid_count_table got=%0d exp>=3", dv_cyc.size());
    end
    // short low glitch must be rejected at the start-bit mid sample
    bc = 0;
    rx = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (k == 40) rx = 1'b1;
      @(negedge clk);
      if (busy) bc++;
    end
    chk_rng("glitch_busy_cycles", bc, 77, 83);
    chk("glitch_hold", int'(data_out), int'(model_last));
    // bad stop bit, line stays low 500 more clocks
    fe0 = n_fe;
    send_frame(8'h3C, 1'b0, 1'b1, 500, f);
    chk("break_busy_while_low", int'(busy), 1);
    repeat (10) @(negedge clk);
    chk("break_busy_after_high", int'(busy), 0);
    chk("break_fe_pulses", n_fe - fe0, 1);
    chk("break_hold", int'(data_out), 8'hF0);
    repeat (100) @(negedge clk);
    // reset during bit 4 of 0x5A
    d5 = 8'h5A;
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = d5[i];
      repeat (BIT) @(negedge clk);
    end
    rx = d5[4];
    repeat (80) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_data_out", int'(data_out), 0);
    chk("midreset_valid", int'(data_valid), 0);
    chk("midreset_frame_err", int'(frame_err), 0);
    chk("midreset_busy", int'(busy), 0);
    rx = 1'b1;
    model_last = 8'h00;
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    send_frame(8'h81, 1'b1, 1'b1, 100, f);
    chk("after_reset_word", int'(data_out), 8'h81);
`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, 100, f);
    chk("parity_good_word", int'(data_out), 8'h07);
    fe0 = n_fe;
    send_frame(8'h07, 1'b1, 1'b0, 100, f);
    chk("parity_bad_fe", n_fe - fe0, 1);
`endif
    // rx held low out of reset: exactly one frame_err, then BREAK until rx rises
    rst_n = 1'b0;
    rx = 1'b0;
    model_last = 8'h00;
    repeat (5) @(negedge clk);
    fe0 = n_fe;
    sb.push_back('{1'b1, 8'h00});
    n_fe_exp++;
    rst_n = 1'b1;
    repeat (2000) @(negedge clk);
    chk("stuck_low_busy", int'(busy), 1);
    chk("stuck_low_fe_pulses", n_fe - fe0, 1);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    chk("stuck_low_release_busy", int'(busy), 0);
    repeat (50) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    chk("total_valid", n_dv, n_dv_exp);
    chk("total_frame_err", n_fe, n_fe_exp);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
